sync_fifo_param: RTL and testbench
==================================

// Module: sync_fifo_param
// PURPOSE
//  Parametrised single-clock FIFO; next generation of the 16x8 FIFO.
//  Adds width/depth parameters, an occupancy count, and almost-full/almost-empty thresholds.
//  Adds sticky overflow/underflow error flags and a selectable first-word-fall-through (FWFT) read mode.
//  Used as the common buffering element between producer/consumer blocks on one clock.
// PARAMETERS
//  WIDTH      8   data word width in bits
//  DEPTH      16  number of entries; power of 2, >= 2
//  AF_THRESH  12  almost_full asserts when count >= AF_THRESH (1..DEPTH)
//  AE_THRESH  4   almost_empty asserts when count <= AE_THRESH (0..DEPTH-1)
//  FWFT       0   0 = standard registered read; 1 = first-word-fall-through
// PORTS
//  clk          in   1                   clock, rising edge
//  rst          in   1                   asynchronous, active-low reset (0 = reset)
//  d            in   WIDTH               write data
//  we           in   1                   write request
//  re           in   1                   read request
//  err_clr      in   1                   synchronous clear of overflow/underflow
//  out          out  WIDTH               read data
//  empty        out  1                   count == 0
//  full         out  1                   count == DEPTH
//  almost_empty out  1                   count <= AE_THRESH
//  almost_full  out  1                   count >= AF_THRESH
//  count        out  $clog2(DEPTH+1)     current occupancy
//  overflow     out  1                   sticky: write dropped
//  underflow    out  1                   sticky: read refused
// BEHAVIOUR
//  Reset (rst=0, async; released synchronously to clk):
//   - Pointers and count go to 0; out=0; overflow=0; underflow=0.
//   - Resulting flags: empty=1, full=0, almost_empty=1, almost_full=0 (given AF_THRESH>=1).
//   - Memory contents are not cleared.
//   - Reset mid-operation discards all contents immediately.
//  Accept rules, evaluated on each rising edge against the registered count:
//   - rd_ok = re & ~empty.
//   - wr_ok = we & (~full | rd_ok).
//   - A write into a full FIFO succeeds only when a read in the same cycle frees the slot.
//   - A read from an empty FIFO is always refused, even if a write occurs in the same cycle.
//  Pointers and count:
//   - wr_ok: mem[wr_ptr] <= d; wr_ptr increments modulo DEPTH (natural wrap).
//   - rd_ok: rd_ptr increments modulo DEPTH.
//   - count: +1 on wr_ok only; -1 on rd_ok only; unchanged on both or neither.
//   - All flags are combinational from the registered count, so they change the cycle after the edge.
//  Read data, FWFT=0:
//   - out <= mem[rd_ptr] on rd_ok, visible the cycle after re is sampled.
//   - out holds its last value otherwise.
//  Read data, FWFT=1:
//   - out = mem[rd_ptr] combinationally whenever empty=0; re pops the shown word.
//   - out = 0 while empty=1.
//   - A write into an empty FIFO is visible on out the cycle after the write edge.
//  Error flags:
//   - overflow <= 1 when we & ~wr_ok.
//   - underflow <= 1 when re & ~rd_ok.
//   - Both are sticky until err_clr=1 or reset.
//   - If err_clr and a new error fall in the same cycle, the flag is set (the error wins).
//  No combinational path from inputs to outputs, except the FWFT out mux from memory/pointer state.
// TESTING
//  1. Reset then idle -> empty=1, full=0, count=0, out=0, overflow=0, underflow=0.
//  2. FWFT=0: write 17 words 0x01..0x11 on back-to-back cycles.
//     -> full=1 after the 16th write; count=16; almost_full=1 from count=12;
//        0x11 dropped, overflow=1.
//  3. Continue from 2, read 17 times.
//     -> out = 0x01..0x10 in order, each one cycle after its re;
//        empty=1 after the 16th read; underflow=1; out holds 0x10.
//  4. Full FIFO, we=1 and re=1 for 4 cycles with d=0xA0..0xA3.
//     -> count stays 16, no overflow; later reads return the old words 5..16, then 0xA0..0xA3.
//     Wrap-around: 40 alternating single writes/reads -> count toggles 0/1; every read matches its write.
//  5. FWFT=1: write 0x5A into an empty FIFO.
//     -> next cycle out=0x5A, empty=0; re=1 pops it -> empty=1, out=0.
//     Simultaneous we/re while empty -> write accepted, underflow=1.
//  6. Mid-stream, rst=0 asynchronously with count=7.
//     -> outputs go to reset values immediately, without waiting for a clock edge.
//     err_clr=1 with overflow set -> overflow=0 the next cycle.

Source files
------------

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, almost-full/empty thresholds,
// sticky overflow/underflow flags and a selectable first-word-fall-through read port.
module sync_fifo_param #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = 12,
  parameter int AE_THRESH = 4,
  parameter int FWFT      = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           d,
  input  logic                       we,
  input  logic                       re,
  input  logic                       err_clr,
  output logic [WIDTH-1:0]           out,
  output logic                       empty,
  output logic                       full,
  output logic                       almost_empty,
  output logic                       almost_full,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       underflow
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_overflow;
  logic             r_underflow;

  logic w_empty;
  logic w_full;
  logic w_rd_ok;
  logic w_wr_ok;

  // Handshake: we/re are requests sampled on every rising edge; a request is
  // accepted (wr_ok/rd_ok) only when the registered occupancy allows it, and a
  // refused request is never retried -- it only raises the matching sticky flag.
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_rd_ok = re & ~w_empty;
  assign w_wr_ok = we & (~w_full | w_rd_ok);

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      r_mem[r_wr_ptr] <= d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_ok) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_rd_ok) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_wr_ok, w_rd_ok})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      // A fresh error in the same cycle as err_clr keeps the flag set.
      if (we & ~w_wr_ok) begin
        r_overflow <= 1'b1;
      end else if (err_clr) begin
        r_overflow <= 1'b0;
      end
      if (re & ~w_rd_ok) begin
        r_underflow <= 1'b1;
      end else if (err_clr) begin
        r_underflow <= 1'b0;
      end
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign out = w_empty ? '0 : r_mem[r_rd_ptr];
    end else begin : g_std
      logic [WIDTH-1:0] r_out;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_out <= '0;
        end else if (w_rd_ok) begin
          r_out <= r_mem[r_rd_ptr];
        end
      end
      assign out = r_out;
    end
  endgenerate

  assign empty        = w_empty;
  assign full         = w_full;
  assign almost_empty = (r_count <= CW'(AE_THRESH));
  assign almost_full  = (r_count >= CW'(AF_THRESH));
  assign count        = r_count;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;
endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: registered-read and FWFT instances share one stimulus
// stream and are checked every cycle against a queue-based model.
module tb_sync_fifo_param;
  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] d;
  logic             we;
  logic             re;
  logic             err_clr;

  logic [WIDTH-1:0] out0, out1;
  logic             empty0, full0, ae0, af0, ov0, un0;
  logic             empty1, full1, ae1, af1, ov1, un1;
  logic [CW-1:0]    count0, count1;

  int n_total = 0;
  int n_pass  = 0;
  bit cmp_en  = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  sync_fifo_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_THRESH(12), .AE_THRESH(4), .FWFT(0)) u_dut0 (
    .clk(clk), .rst(rst), .d(d), .we(we), .re(re), .err_clr(err_clr),
    .out(out0), .empty(empty0), .full(full0), .almost_empty(ae0), .almost_full(af0),
    .count(count0), .overflow(ov0), .underflow(un0)
  );

  sync_fifo_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_THRESH(12), .AE_THRESH(4), .FWFT(1)) u_dut1 (
    .clk(clk), .rst(rst), .d(d), .we(we), .re(re), .err_clr(err_clr),
    .out(out1), .empty(empty1), .full(full1), .almost_empty(ae1), .almost_full(af1),
    .count(count1), .overflow(ov1), .underflow(un1)
  );

  // ---------------- behavioural model ----------------
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] m_out0 = '0;
  logic             m_ov   = 1'b0;
  logic             m_un   = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp_q.delete();
      m_out0 = '0;
      m_ov   = 1'b0;
      m_un   = 1'b0;
    end else begin
      bit rd_ok, wr_ok;
      rd_ok = re && (exp_q.size() != 0);
      wr_ok = we && ((exp_q.size() != DEPTH) || rd_ok);
      if (rd_ok) m_out0 = exp_q.pop_front();
      if (wr_ok) exp_q.push_back(d);
      if (we && !wr_ok) m_ov = 1'b1;
      else if (err_clr) m_ov = 1'b0;
      if (re && !rd_ok) m_un = 1'b1;
      else if (err_clr) m_un = 1'b0;
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      int sz;
      logic [WIDTH-1:0] fw;
      sz = exp_q.size();
      fw = (sz == 0) ? '0 : exp_q[0];
      check("count0", 32'(count0), 32'(sz));
      check("count1", 32'(count1), 32'(sz));
      check("empty0", 32'(empty0), 32'(sz == 0));
      check("empty1", 32'(empty1), 32'(sz == 0));
      check("full0",  32'(full0),  32'(sz == DEPTH));
      check("full1",  32'(full1),  32'(sz == DEPTH));
      check("ae0",    32'(ae0),    32'(sz <= 4));
      check("ae1",    32'(ae1),    32'(sz <= 4));
      check("af0",    32'(af0),    32'(sz >= 12));
      check("af1",    32'(af1),    32'(sz >= 12));
      check("ov0",    32'(ov0),    32'(m_ov));
      check("ov1",    32'(ov1),    32'(m_ov));
      check("un0",    32'(un0),    32'(m_un));
      check("un1",    32'(un1),    32'(m_un));
      check("out0",   32'(out0),   32'(m_out0));
      check("out1",   32'(out1),   32'(fw));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic w, input logic r, input logic [WIDTH-1:0] dv, input logic clr);
    @(negedge clk);
    #1;
    we = w; re = r; d = dv; err_clr = clr;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, '0, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b0; we = 1'b0; re = 1'b0; d = '0; err_clr = 1'b0;
    cmp_en = 1'b1;
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    idle();

    // 1: reset state
    check("t1_empty", 32'(empty0), 32'd1);
    check("t1_count", 32'(count0), 32'd0);
    check("t1_out",   32'(out0),   32'd0);
    check("t1_ae",    32'(ae0),    32'd1);

    // 2: fill past full
    for (int i = 1; i <= 16; i++) begin
      drive(1'b1, 1'b0, WIDTH'(i), 1'b0);
      if (i == 13) check("t2_af_at12", 32'(af0), 32'd1);
    end
    drive(1'b1, 1'b0, 8'h11, 1'b0);
    check("t2_full",  32'(full0),  32'd1);
    check("t2_count", 32'(count0), 32'd16);
    idle();
    check("t2_ovf",   32'(ov0),    32'd1);

    // 3: drain past empty
    for (int i = 1; i <= 17; i++) begin
      drive(1'b0, 1'b1, '0, 1'b0);
      if (i == 2) check("t3_first", 32'(out0), 32'h01);
    end
    idle();
    check("t3_out_hold", 32'(out0),   32'h10);
    check("t3_empty",    32'(empty0), 32'd1);
    check("t3_unf",      32'(un0),    32'd1);

    // 4: simultaneous read/write while full, then wrap-around ping-pong
    drive(1'b0, 1'b0, '0, 1'b1);
    for (int i = 1; i <= 16; i++) drive(1'b1, 1'b0, WIDTH'(i), 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, WIDTH'(8'hA0 + i), 1'b0);
    idle();
    check("t4_count", 32'(count0), 32'd16);
    check("t4_noovf", 32'(ov0),    32'd0);
    check("t4_out",   32'(out0),   32'h04);
    for (int i = 0; i < 16; i++) drive(1'b0, 1'b1, '0, 1'b0);
    idle();
    check("t4_last",  32'(out0),   32'hA3);
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b0, WIDTH'(i * 7 + 3), 1'b0);
      drive(1'b0, 1'b1, '0, 1'b0);
    end
    idle();
    check("t4_wrap_out", 32'(out0), 32'((19 * 7 + 3) & 8'hFF));

    // 5: FWFT behaviour
    drive(1'b1, 1'b0, 8'h5A, 1'b0);
    idle();
    check("t5_fwft_out",   32'(out1),   32'h5A);
    check("t5_fwft_empty", 32'(empty1), 32'd0);
    drive(1'b0, 1'b1, '0, 1'b0);
    idle();
    check("t5_pop_empty",  32'(empty1), 32'd1);
    check("t5_pop_out",    32'(out1),   32'd0);
    drive(1'b1, 1'b1, 8'h33, 1'b0);
    idle();
    check("t5_unf",        32'(un1),    32'd1);
    check("t5_cnt",        32'(count1), 32'd1);
    check("t5_out",        32'(out1),   32'h33);

    // 6: asynchronous reset mid-stream, then err_clr
    for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, WIDTH'(8'hC0 + i), 1'b0);
    idle();
    check("t6_cnt7", 32'(count0), 32'd7);
    #2 rst = 1'b0;
    #1;
    check("t6_rst_count", 32'(count0), 32'd0);
    check("t6_rst_empty", 32'(empty1), 32'd1);
    check("t6_rst_out1",  32'(out1),   32'd0);
    check("t6_rst_out0",  32'(out0),   32'd0);
    check("t6_rst_unf",   32'(un0),    32'd0);
    @(negedge clk);
    #1 rst = 1'b1;
    for (int i = 0; i < 17; i++) drive(1'b1, 1'b0, WIDTH'(i), 1'b0);
    idle();
    check("t6_ovf_set", 32'(ov0), 32'd1);
    drive(1'b0, 1'b0, '0, 1'b1);
    idle();
    check("t6_ovf_clr", 32'(ov0), 32'd0);
    drive(1'b1, 1'b0, 8'hEE, 1'b1);
    idle();
    check("t6_err_wins", 32'(ov0), 32'd1);

    repeat (2) idle();
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
